// File: rtl/plot_pkg.sv
// Shared types and helpers for the pixel-plot sink: screen geometry, pixel
// coordinate types and the clear-FSM state encoding.
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COL_W    = 3;
  localparam int ADDR_W   = 15;

  typedef logic [7:0]        px_x_t;
  typedef logic [6:0]        px_y_t;
  typedef logic [COL_W-1:0]  colour_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Row-major address y*width + x built from shifted copies of y, one per set
  // bit of the constant width, so no multiplier is inferred.
  function automatic fb_addr_t pixel_addr(input px_x_t x, input px_y_t y, input int width);
    fb_addr_t acc;
    acc = fb_addr_t'(x);
    for (int i = 0; i < ADDR_W; i++) begin
      if (width[i]) acc = acc + (fb_addr_t'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer: one synchronous write port and one registered
// read port with read-before-write behaviour on an address collision.
module fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int DATA_W = 3,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset, which keeps them
  // mappable onto block RAM; contents are defined only after a screen clear.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/plot_sink.sv
// Receiving end of the pixel-plot interface: captures plots into the
// framebuffer, runs the whole-screen clear and keeps counts and a bounding box.
module plot_sink
  import plot_pkg::*;
#(
  parameter int SCREEN_W = plot_pkg::SCREEN_W,
  parameter int SCREEN_H = plot_pkg::SCREEN_H,
  parameter int COL_W    = plot_pkg::COL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       plot_x,
  input  logic [6:0]       plot_y,
  input  logic [COL_W-1:0] plot_colour,
  input  logic             plot_en,
  output logic             plot_ready,
  input  logic             clr_start,
  input  logic [COL_W-1:0] clr_colour,
  output logic             clr_done,
  input  logic             rd_en,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  output logic             rd_valid,
  output logic [COL_W-1:0] rd_colour,
  output logic [14:0]      plot_count,
  output logic [14:0]      drop_count,
  output logic             bbox_valid,
  output logic [7:0]       bbox_min_x,
  output logic [7:0]       bbox_max_x,
  output logic [6:0]       bbox_min_y,
  output logic [6:0]       bbox_max_y
);

  localparam px_x_t    X_LIM     = px_x_t'(SCREEN_W);
  localparam px_y_t    Y_LIM     = px_y_t'(SCREEN_H);
  localparam fb_addr_t LAST_ADDR = fb_addr_t'(SCREEN_W * SCREEN_H - 1);

  clr_state_e       state;
  fb_addr_t         clr_addr;
  logic [COL_W-1:0] clr_col_q;

  logic             accept, drop, clear_go;
  logic             rd_in_range, rd_hit_q;
  logic             ram_we;
  fb_addr_t         ram_waddr;
  logic [COL_W-1:0] ram_wdata, ram_rdata;

  assign plot_ready = (state != CLEAR);
  assign clr_done   = (state == DONE);
  assign clear_go   = (state == IDLE) && clr_start;

  assign accept      = plot_en && plot_ready && (plot_x < X_LIM) && (plot_y < Y_LIM);
  assign drop        = plot_en && !accept;
  assign rd_in_range = (rd_x < X_LIM) && (rd_y < Y_LIM);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = pixel_addr(plot_x, plot_y, SCREEN_W);
    ram_wdata = plot_colour;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = clr_col_q;
    end else if (accept) begin
      ram_we = 1'b1;
    end
  end

  fb_ram #(
    .DEPTH (SCREEN_W * SCREEN_H),
    .DATA_W(COL_W),
    .ADDR_W(ADDR_W)
  ) u_fb_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (rd_en && rd_in_range),
    .raddr(pixel_addr(rd_x, rd_y, SCREEN_W)),
    .rdata(ram_rdata)
  );

  // Out-of-range and idle cycles present 0 without depending on RAM contents.
  assign rd_colour = rd_hit_q ? ram_rdata : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_hit_q <= rd_en && rd_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_addr  <= '0;
      clr_col_q <= '0;
    end else begin
      case (state)
        IDLE: if (clr_start) begin
          state     <= CLEAR;
          clr_col_q <= clr_colour;
          clr_addr  <= '0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) state <= DONE;
        end
        DONE:    if (!clr_start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_count <= '0;
      drop_count <= '0;
      bbox_valid <= 1'b0;
      bbox_min_x <= '0;
      bbox_max_x <= '0;
      bbox_min_y <= '0;
      bbox_max_y <= '0;
    end else if (clear_go) begin
      plot_count <= '0;
      drop_count <= '0;
      bbox_valid <= 1'b0;
    end else begin
      if (accept && plot_count != '1) plot_count <= plot_count + 1'b1;
      if (drop && drop_count != '1)   drop_count <= drop_count + 1'b1;
      if (accept) begin
        bbox_valid <= 1'b1;
        if (!bbox_valid || plot_x < bbox_min_x) bbox_min_x <= plot_x;
        if (!bbox_valid || plot_x > bbox_max_x) bbox_max_x <= plot_x;
        if (!bbox_valid || plot_y < bbox_min_y) bbox_min_y <= plot_y;
        if (!bbox_valid || plot_y > bbox_max_y) bbox_max_y <= plot_y;
      end
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: a shadow framebuffer predicts every read,
// expected read results are queued at request time and popped on rd_valid.
module tb_plot_sink;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] plot_x = '0;
  logic [6:0] plot_y = '0;
  logic [2:0] plot_colour = '0;
  logic       plot_en = 1'b0;
  logic       plot_ready;
  logic       clr_start = 1'b0;
  logic [2:0] clr_colour = '0;
  logic       clr_done;
  logic       rd_en = 1'b0;
  logic [7:0] rd_x = '0;
  logic [6:0] rd_y = '0;
  logic       rd_valid;
  logic [2:0] rd_colour;
  logic [14:0] plot_count, drop_count;
  logic       bbox_valid;
  logic [7:0] bbox_min_x, bbox_max_x;
  logic [6:0] bbox_min_y, bbox_max_y;

  always #5 clk = ~clk;

  plot_sink dut (
    .clk(clk), .rst_n(rst_n),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot_en(plot_en),
    .plot_ready(plot_ready),
    .clr_start(clr_start), .clr_colour(clr_colour), .clr_done(clr_done),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_colour(rd_colour),
    .plot_count(plot_count), .drop_count(drop_count),
    .bbox_valid(bbox_valid),
    .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
    .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y)
  );

  typedef struct {
    logic [2:0] col;
    int         x;
    int         y;
  } rd_exp_t;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] shadow [W*H];
  rd_exp_t    exp_q [$];
  logic       exp_rd_v;
  int         exp_plot = 0, exp_drop = 0;
  bit         exp_bv = 0;
  int         exp_minx = 0, exp_maxx = 0, exp_miny = 0, exp_maxy = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-side scoreboard: rd_valid must follow rd_en by one cycle, and each
  // valid beat consumes the oldest expected colour.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_rd_v <= 1'b0;
    else        exp_rd_v <= rd_en;
  end

  always @(negedge clk) begin
    if (rst_n && (exp_rd_v || rd_valid)) begin
      checks++;
      if (rd_valid !== exp_rd_v) begin
        errors++;
        $display("FAIL rd_valid got %b want %b", rd_valid, exp_rd_v);
      end
    end
    if (rst_n && exp_rd_v) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_queue empty on read beat");
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (rd_colour !== e.col) begin
          errors++;
          $display("FAIL rd_colour(%0d,%0d) got %b want %b", e.x, e.y, rd_colour, e.col);
        end
      end
    end
  end

  // Present one read request this cycle; rd_en is left high for the caller.
  task automatic req_read(int x, int y);
    rd_exp_t e;
    rd_en = 1'b1;
    rd_x  = 8'(x);
    rd_y  = 7'(y);
    e.x = x;
    e.y = y;
    e.col = (x < W && y < H) ? shadow[y*W + x] : 3'b000;
    exp_q.push_back(e);
  endtask

  task automatic do_read(int x, int y);
    req_read(x, y);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drive_plot(int x, int y, logic [2:0] c);
    plot_en = 1'b1;
    plot_x = 8'(x);
    plot_y = 7'(y);
    plot_colour = c;
  endtask

  // Model the acceptance outcome of a plot presented while plots are accepted.
  task automatic model_plot(int x, int y, logic [2:0] c);
    if (x < W && y < H) begin
      shadow[y*W + x] = c;
      exp_plot++;
      if (!exp_bv) begin
        exp_bv = 1; exp_minx = x; exp_maxx = x; exp_miny = y; exp_maxy = y;
      end else begin
        if (x < exp_minx) exp_minx = x;
        if (x > exp_maxx) exp_maxx = x;
        if (y < exp_miny) exp_miny = y;
        if (y > exp_maxy) exp_maxy = y;
      end
    end else begin
      exp_drop++;
    end
  endtask

  task automatic do_plot(int x, int y, logic [2:0] c);
    drive_plot(x, y, c);
    model_plot(x, y, c);
    tick();
    plot_en = 1'b0;
  endtask

  // Runs a full clear; for drop_cycles cycles inside CLEAR a plot is also
  // presented, each of which must be refused.
  task automatic run_clear(logic [2:0] c, int drop_cycles);
    int n;
    clr_colour = c;
    clr_start  = 1'b1;
    tick();
    n = 1;
    for (int i = 0; i < drop_cycles; i++) begin
      drive_plot(159, 119, ~c);
      checks++;
      if (plot_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_plot_ready got %b want 0", plot_ready);
      end
      tick();
      n++;
    end
    plot_en = 1'b0;
    while (!clr_done && n < 20100) begin
      tick();
      n++;
    end
    checks++;
    if (n < 19199 || n > 19201) begin
      errors++;
      $display("FAIL clear_cycles got %0d want 19200+-1", n);
    end
    for (int i = 0; i < W*H; i++) shadow[i] = c;
    exp_plot = 0;
    exp_drop = drop_cycles;
    exp_bv   = 0;
    checks++;
    if (plot_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_plot_ready got %b want 1", plot_ready);
    end
    clr_start = 1'b0;
    tick();
    checks++;
    if (clr_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_fall got %b want 0", clr_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({plot_ready, clr_done, rd_valid, rd_colour, plot_count, drop_count, bbox_valid,
         bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {1'b1, 1'b0, 1'b0, 3'b0, 15'd0,
         15'd0, 1'b0, 8'd0, 8'd0, 7'd0, 7'd0}) begin
      errors++;
      $display("FAIL reset_state got ready=%b done=%b valid=%b col=%b pc=%0d dc=%0d bv=%b want 1 0 0 000 0 0 0",
               plot_ready, clr_done, rd_valid, rd_colour, plot_count, drop_count, bbox_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    run_clear(3'b001, 0);
    do_read(0, 0);
    do_read(159, 119);
    tick();
    checks++;
    if (plot_count !== 15'd0) begin
      errors++;
      $display("FAIL clear_plot_count got %0d want 0", plot_count);
    end
  endtask

  task automatic test_plot();
    do_plot(80, 60, 3'b010);
    do_read(80, 60);
    tick();
    checks++;
    if (plot_count !== 15'(exp_plot)) begin
      errors++;
      $display("FAIL plot_count got %0d want %0d", plot_count, exp_plot);
    end
    checks++;
    if ({bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {1'b1, 8'd80, 8'd80, 7'd60, 7'd60}) begin
      errors++;
      $display("FAIL plot_bbox got v=%b (%0d,%0d)-(%0d,%0d) want 1 (80,60)-(80,60)",
               bbox_valid, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y);
    end
    // Same-cycle read and write of one pixel returns the old colour.
    req_read(10, 5);
    drive_plot(10, 5, 3'b111);
    model_plot(10, 5, 3'b111);
    tick();
    rd_en = 1'b0;
    plot_en = 1'b0;
    do_plot(10, 5, 3'b100);
    do_read(10, 5);
    // Back-to-back reads across both screen corners.
    req_read(0, 119); tick();
    req_read(159, 0); tick();
    req_read(80, 60); tick();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    int pc;
    pc = exp_plot;
    do_plot(160, 10, 3'b111);
    do_plot(5, 120, 3'b111);
    do_read(0, 10);
    do_read(5, 0);
    do_read(200, 3);
    tick();
    checks++;
    if (drop_count !== 15'd2) begin
      errors++;
      $display("FAIL drop_count got %0d want 2", drop_count);
    end
    checks++;
    if (plot_count !== 15'(pc)) begin
      errors++;
      $display("FAIL drop_plot_count got %0d want %0d", plot_count, pc);
    end
  endtask

  task automatic test_plot_during_clear();
    run_clear(3'b110, 100);
    checks++;
    if (drop_count !== 15'd100 || plot_count !== 15'd0 || bbox_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_drops got dc=%0d pc=%0d bv=%b want 100 0 0", drop_count, plot_count, bbox_valid);
    end
    for (int a = 0; a < W*H; a += 13) begin
      req_read(a % W, a / W);
      tick();
    end
    req_read(159, 119);
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  // Circle of diameter 80 about (80,60) in green, drawn midpoint-style.
  task automatic test_shape();
    int x, y, d;
    x = 40; y = 0; d = 1 - 40;
    while (x >= y) begin
      do_plot(80 + x, 60 + y, 3'b010); do_plot(80 - x, 60 + y, 3'b010);
      do_plot(80 + x, 60 - y, 3'b010); do_plot(80 - x, 60 - y, 3'b010);
      do_plot(80 + y, 60 + x, 3'b010); do_plot(80 - y, 60 + x, 3'b010);
      do_plot(80 + y, 60 - x, 3'b010); do_plot(80 - y, 60 - x, 3'b010);
      y++;
      if (d < 0) d += 2*y + 1;
      else begin x--; d += 2*(y - x) + 1; end
    end
    tick();
    checks++;
    if (plot_count !== 15'(exp_plot) || exp_plot == 0) begin
      errors++;
      $display("FAIL shape_plot_count got %0d want %0d", plot_count, exp_plot);
    end
    checks++;
    if ({bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !==
        {1'b1, 8'(exp_minx), 8'(exp_maxx), 7'(exp_miny), 7'(exp_maxy)}) begin
      errors++;
      $display("FAIL shape_bbox got v=%b (%0d,%0d)-(%0d,%0d) want (%0d,%0d)-(%0d,%0d)",
               bbox_valid, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y,
               exp_minx, exp_miny, exp_maxx, exp_maxy);
    end
    checks++;
    if (bbox_min_x < 8'd40 || bbox_max_x > 8'd120 || bbox_min_y < 7'd20 || bbox_max_y > 7'd100) begin
      errors++;
      $display("FAIL shape_bbox_bounds got (%0d,%0d)-(%0d,%0d) want inside (40,20)-(120,100)",
               bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y);
    end
    for (int a = 0; a < W*H; a++) begin
      req_read(a % W, a / W);
      tick();
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    clr_colour = 3'b100;
    clr_start  = 1'b1;
    repeat (500) tick();
    clr_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({plot_ready, clr_done, rd_valid, plot_count, drop_count, bbox_valid} !==
        {1'b1, 1'b0, 1'b0, 15'd0, 15'd0, 1'b0}) begin
      errors++;
      $display("FAIL midclear_reset got ready=%b done=%b valid=%b pc=%0d dc=%0d bv=%b want 1 0 0 0 0 0",
               plot_ready, clr_done, rd_valid, plot_count, drop_count, bbox_valid);
    end
    exp_plot = 0; exp_drop = 0; exp_bv = 0;
    tick();
    rst_n = 1'b1;
    tick();
    run_clear(3'b011, 0);
    do_read(0, 0);
    do_read(159, 119);
    do_plot(3, 4, 3'b101);
    do_read(3, 4);
    tick();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_plot();
    test_drop();
    test_plot_during_clear();
    test_shape();
    test_reset_mid_clear();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
